// File: rtl/enc_8b10b_pkg.sv
// Shared 8b/10b encoder constants and helpers.
// All code tables hold the RD- form in abcdei / fghj order ('a' at MSB).
// The RD+ form of an alternating sub-block is the bitwise complement.
package enc_8b10b_pkg;

  // 5b/6b RD- codes indexed by EDCBA
  localparam logic [5:0] D6B_RDM [0:31] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  // 3b/4b RD- codes indexed by HGF (x.7 entry is the primary P7 form)
  localparam logic [3:0] D4B_RDM [0:7] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
  };

  // Balanced D.7 sub-block that still alternates with RD
  localparam logic [5:0] D7_6B_RDM  = 6'b111000;
  // Alternate x.7 sub-block used by the A7 cases and every K.x.7
  localparam logic [3:0] A7_4B_RDM  = 4'b0111;
  // 6b block shared by all K28.y codes
  localparam logic [5:0] K28_6B_RDM = 6'b001111;

  // Legal control characters: K28.0..K28.7 plus these K.x.7
  localparam logic [4:0] K28_X       = 5'd28;
  localparam int         K_X7_NUM    = 4;
  localparam logic [4:0] K_X7_LIST [0:3] = '{5'd23, 5'd27, 5'd29, 5'd30};

  // Byte substituted for any K request when only K28.5 may be sent
  localparam logic [7:0] K28_5_BYTE  = 8'hBC;

  // Disparity (ones minus zeros) of a sub-block occupying the low nbits of sb
  function automatic logic signed [4:0] sb_disparity(input logic [5:0] sb,
                                                     input logic [2:0] nbits);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < 6; i++) begin
      ones = ones + {3'b000, sb[i]};
    end
    return $signed({ones, 1'b0}) - $signed({2'b00, nbits});
  endfunction

endpackage

// File: rtl/enc_8b10b_multi_if.sv
// Word-level bus of the multi-byte 8b/10b encoder.
// master drives the data/control side, slave is the encoder.
interface enc_8b10b_multi_if #(
  parameter int bytes = 2
);
  logic                  enable;
  logic                  init_rd_n;
  logic                  init_rd_val;
  logic [bytes-1:0]      k_char;
  logic [bytes*8-1:0]    data_in;
  logic [bytes*10-1:0]   data_out;
  logic                  rd;
  logic [bytes-1:0]      k_err;
  logic                  valid_out;

  modport master (
    output enable, init_rd_n, init_rd_val, k_char, data_in,
    input  data_out, rd, k_err, valid_out
  );

  modport slave (
    input  enable, init_rd_n, init_rd_val, k_char, data_in,
    output data_out, rd, k_err, valid_out
  );
endinterface

// File: rtl/enc_8b10b_byte.sv
// Combinational single-byte 8b/10b encoder with running-disparity in/out.
// Illegal K requests fall back to the D code and raise k_err.
module enc_8b10b_byte
  import enc_8b10b_pkg::*;
(
  input  logic       rd_in,
  input  logic       k,
  input  logic [7:0] data,
  output logic [9:0] code,
  output logic       rd_out,
  output logic       k_err
);

  logic [4:0] x_s;
  logic [2:0] y_s;
  logic       is_k28_s;
  logic       is_kx7_s;
  logic       k_ok_s;
  logic [5:0] rdm6_s;
  logic [5:0] code6_s;
  logic       unbal6_s;
  logic       rd6_s;
  logic       use_a7_s;
  logic [3:0] base4_s;
  logic       alt4_s;
  logic [3:0] code4_s;

  assign x_s  = data[4:0];
  assign y_s  = data[7:5];
  assign code = {code6_s, code4_s};

  // Decide whether the K request names a legal control code
  always_comb begin
    is_kx7_s = 1'b0;
    for (int i = 0; i < K_X7_NUM; i++) begin
      is_kx7_s = is_kx7_s | ((y_s == 3'd7) && (x_s == K_X7_LIST[i]));
    end
    is_k28_s = (x_s == K28_X);
    k_ok_s   = k & (is_k28_s | is_kx7_s);
    k_err    = k & ~k_ok_s;
  end

  // 5b/6b selection; D.7 alternates but leaves RD unchanged
  always_comb begin
    if (k_ok_s && is_k28_s) begin
      rdm6_s = K28_6B_RDM;
    end else begin
      rdm6_s = D6B_RDM[x_s];
    end
    unbal6_s = (sb_disparity(rdm6_s, 3'd6) != 5'sd0);
    if (rd_in && (unbal6_s || (rdm6_s == D7_6B_RDM))) begin
      code6_s = ~rdm6_s;
    end else begin
      code6_s = rdm6_s;
    end
    rd6_s = rd_in ^ unbal6_s;
  end

  // 3b/4b selection from the RD after the 6b block, with A7 substitution
  always_comb begin
    use_a7_s = (y_s == 3'd7) &&
               (k_ok_s ||
                (!rd6_s && ((x_s == 5'd17) || (x_s == 5'd18) || (x_s == 5'd20))) ||
                ( rd6_s && ((x_s == 5'd11) || (x_s == 5'd13) || (x_s == 5'd14))));
    if (use_a7_s) begin
      base4_s = A7_4B_RDM;
    end else begin
      base4_s = D4B_RDM[y_s];
    end
    alt4_s = (sb_disparity({2'b00, base4_s}, 3'd4) != 5'sd0) || (y_s == 3'd3);
    if (k_ok_s && is_k28_s) begin
      // K28 codes are fully complemented between RD- and RD+, so the
      // 4b block follows the incoming RD, balanced forms included
      if (rd_in ^ alt4_s) begin
        code4_s = ~base4_s;
      end else begin
        code4_s = base4_s;
      end
    end else if (rd6_s && alt4_s) begin
      code4_s = ~base4_s;
    end else begin
      code4_s = base4_s;
    end
    rd_out = rd6_s ^ (sb_disparity({2'b00, code4_s}, 3'd4) != 5'sd0);
  end

endmodule

// File: rtl/enc_8b10b_multi.sv
// Multi-byte 8b/10b encoder: chains per-byte encoders from the top byte
// down to byte 0 and registers the word, RD and K-error flags.
module enc_8b10b_multi
  import enc_8b10b_pkg::*;
#(
  parameter int bytes      = 2,
  parameter bit k28_5_only = 1'b0,
  parameter bit init_mode  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  enc_8b10b_multi_if.slave       bus
);

  logic                  start_rd_s;
  logic                  word_rd_s;
  logic [bytes*10-1:0]   code_s;
  logic [bytes-1:0]      k_err_s;

  logic [bytes*10-1:0]   data_out_r;
  logic                  rd_r;
  logic [bytes-1:0]      k_err_r;
  logic                  valid_out_r;

  // Starting RD: an immediate init overrides the stored RD for this word
  always_comb begin
    if ((init_mode == 1'b1) && (bus.init_rd_n == 1'b0)) begin
      start_rd_s = bus.init_rd_val;
    end else begin
      start_rd_s = rd_r;
    end
  end

  for (genvar i = 0; i < bytes; i++) begin : g_byte
    logic [7:0] byte_data_s;
    logic       rd_in_s;
    logic       rd_out_s;

    if (k28_5_only) begin : g_k28_5
      assign byte_data_s = bus.k_char[i] ? K28_5_BYTE : bus.data_in[8*i +: 8];
    end else begin : g_raw
      assign byte_data_s = bus.data_in[8*i +: 8];
    end

    if (i == bytes - 1) begin : g_first
      assign rd_in_s = start_rd_s;
    end else begin : g_next
      assign rd_in_s = g_byte[i+1].rd_out_s;
    end

    enc_8b10b_byte u_byte (
      .rd_in  (rd_in_s),
      .k      (bus.k_char[i]),
      .data   (byte_data_s),
      .code   (code_s[10*i +: 10]),
      .rd_out (rd_out_s),
      .k_err  (k_err_s[i])
    );
  end

  assign word_rd_s = g_byte[0].rd_out_s;

  // Output stage; a deferred init load wins over the encoded RD even when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r  <= '0;
      rd_r        <= 1'b0;
      k_err_r     <= '0;
      valid_out_r <= 1'b0;
    end else begin
      valid_out_r <= bus.enable;
      if (bus.enable) begin
        data_out_r <= code_s;
        k_err_r    <= k_err_s;
      end else begin
        data_out_r <= data_out_r;
        k_err_r    <= k_err_r;
      end
      if ((init_mode == 1'b0) && (bus.init_rd_n == 1'b0)) begin
        rd_r <= bus.init_rd_val;
      end else if (bus.enable) begin
        rd_r <= word_rd_s;
      end else begin
        rd_r <= rd_r;
      end
    end
  end

  assign bus.data_out  = data_out_r;
  assign bus.rd        = rd_r;
  assign bus.k_err     = k_err_r;
  assign bus.valid_out = valid_out_r;

endmodule

// File: tb/tb_enc_8b10b_multi.sv
// Directed bench for enc_8b10b_multi: four instances cover bytes=1, bytes=2,
// the K28.5-only option and the deferred RD init mode.
module tb_enc_8b10b_multi;

  logic clk = 1'b0;
  logic rst;
  int   n_compared = 0;
  int   n_mismatch = 0;

  always #5 clk = ~clk;

  enc_8b10b_multi_if #(.bytes(1)) if_b1  ();
  enc_8b10b_multi_if #(.bytes(2)) if_b2  ();
  enc_8b10b_multi_if #(.bytes(1)) if_k5  ();
  enc_8b10b_multi_if #(.bytes(1)) if_im0 ();

  enc_8b10b_multi #(.bytes(1), .k28_5_only(1'b0), .init_mode(1'b1)) u_b1  (.clk(clk), .rst(rst), .bus(if_b1));
  enc_8b10b_multi #(.bytes(2), .k28_5_only(1'b0), .init_mode(1'b1)) u_b2  (.clk(clk), .rst(rst), .bus(if_b2));
  enc_8b10b_multi #(.bytes(1), .k28_5_only(1'b1), .init_mode(1'b1)) u_k5  (.clk(clk), .rst(rst), .bus(if_k5));
  enc_8b10b_multi #(.bytes(1), .k28_5_only(1'b0), .init_mode(1'b0)) u_im0 (.clk(clk), .rst(rst), .bus(if_im0));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b1(input logic en, input logic irn, input logic irv, input logic k, input logic [7:0] d);
    if_b1.enable = en; if_b1.init_rd_n = irn; if_b1.init_rd_val = irv; if_b1.k_char = k; if_b1.data_in = d;
  endtask

  task automatic drive_b2(input logic en, input logic irn, input logic irv, input logic [1:0] k, input logic [15:0] d);
    if_b2.enable = en; if_b2.init_rd_n = irn; if_b2.init_rd_val = irv; if_b2.k_char = k; if_b2.data_in = d;
  endtask

  task automatic drive_k5(input logic en, input logic irn, input logic irv, input logic k, input logic [7:0] d);
    if_k5.enable = en; if_k5.init_rd_n = irn; if_k5.init_rd_val = irv; if_k5.k_char = k; if_k5.data_in = d;
  endtask

  task automatic drive_im0(input logic en, input logic irn, input logic irv, input logic k, input logic [7:0] d);
    if_im0.enable = en; if_im0.init_rd_n = irn; if_im0.init_rd_val = irv; if_im0.k_char = k; if_im0.data_in = d;
  endtask

  task automatic chk_b1(input string tag, input logic [9:0] d, input logic r, input logic ke, input logic v);
    check_val({"b1.", tag, ".data"},  32'(if_b1.data_out),  32'(d));
    check_val({"b1.", tag, ".rd"},    32'(if_b1.rd),        32'(r));
    check_val({"b1.", tag, ".k_err"}, 32'(if_b1.k_err),     32'(ke));
    check_val({"b1.", tag, ".valid"}, 32'(if_b1.valid_out), 32'(v));
  endtask

  task automatic chk_b2(input string tag, input logic [19:0] d, input logic r, input logic [1:0] ke, input logic v);
    check_val({"b2.", tag, ".data"},  32'(if_b2.data_out),  32'(d));
    check_val({"b2.", tag, ".rd"},    32'(if_b2.rd),        32'(r));
    check_val({"b2.", tag, ".k_err"}, 32'(if_b2.k_err),     32'(ke));
    check_val({"b2.", tag, ".valid"}, 32'(if_b2.valid_out), 32'(v));
  endtask

  task automatic chk_k5(input string tag, input logic [9:0] d, input logic r, input logic ke, input logic v);
    check_val({"k5.", tag, ".data"},  32'(if_k5.data_out),  32'(d));
    check_val({"k5.", tag, ".rd"},    32'(if_k5.rd),        32'(r));
    check_val({"k5.", tag, ".k_err"}, 32'(if_k5.k_err),     32'(ke));
    check_val({"k5.", tag, ".valid"}, 32'(if_k5.valid_out), 32'(v));
  endtask

  task automatic chk_im0(input string tag, input logic [9:0] d, input logic r, input logic ke, input logic v);
    check_val({"im0.", tag, ".data"},  32'(if_im0.data_out),  32'(d));
    check_val({"im0.", tag, ".rd"},    32'(if_im0.rd),        32'(r));
    check_val({"im0.", tag, ".k_err"}, 32'(if_im0.k_err),     32'(ke));
    check_val({"im0.", tag, ".valid"}, 32'(if_im0.valid_out), 32'(v));
  endtask

  initial begin
    // Reset with enable high: reset must win
    rst = 1'b1;
    drive_b1 (1'b1, 1'b0, 1'b1, 1'b0, 8'hB5);
    drive_b2 (1'b0, 1'b1, 1'b0, 2'b00, 16'h0000);
    drive_k5 (1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive_im0(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick(); tick();
    chk_b1 ("reset", 10'd0, 1'b0, 1'b0, 1'b0);
    chk_b2 ("reset", 20'd0, 1'b0, 2'b00, 1'b0);
    chk_k5 ("reset", 10'd0, 1'b0, 1'b0, 1'b0);
    chk_im0("reset", 10'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // ---------------- bytes=1 ----------------
    drive_b1(1'b1, 1'b1, 1'b0, 1'b0, 8'hB5); tick();
    chk_b1("d21_5", 10'b1010101010, 1'b0, 1'b0, 1'b1);
    drive_b1(1'b1, 1'b1, 1'b0, 1'b1, 8'hBC); tick();
    chk_b1("k28_5_rdm", 10'b0011111010, 1'b1, 1'b0, 1'b1);
    tick();
    chk_b1("k28_5_rdp", 10'b1100000101, 1'b0, 1'b0, 1'b1);
    drive_b1(1'b1, 1'b1, 1'b0, 1'b0, 8'hF1); tick();
    chk_b1("d17_7_a7", 10'b1000110111, 1'b1, 1'b0, 1'b1);
    drive_b1(1'b1, 1'b1, 1'b0, 1'b0, 8'hEB); tick();
    chk_b1("d11_7_a7", 10'b1101001000, 1'b0, 1'b0, 1'b1);
    drive_b1(1'b1, 1'b1, 1'b0, 1'b1, 8'h00); tick();
    chk_b1("k0_0_err", 10'b1001110100, 1'b0, 1'b1, 1'b1);
    drive_b1(1'b1, 1'b1, 1'b0, 1'b1, 8'hF7); tick();
    chk_b1("k23_7", 10'b1110101000, 1'b0, 1'b0, 1'b1);
    drive_b1(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    chk_b1("init_imm", 10'b0110001011, 1'b1, 1'b0, 1'b1);
    drive_b1(1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_b1("hold", 10'b0110001011, 1'b1, 1'b0, 1'b0);
    end
    drive_b1(1'b1, 1'b1, 1'b0, 1'b0, 8'h63); tick();
    chk_b1("d3_3_rdp", 10'b1100010011, 1'b1, 1'b0, 1'b1);
    drive_b1(1'b1, 1'b1, 1'b0, 1'b0, 8'h07); tick();
    chk_b1("d7_0_rdp", 10'b0001110100, 1'b0, 1'b0, 1'b1);
    drive_b1(1'b1, 1'b1, 1'b0, 1'b1, 8'hBC); tick();
    chk_b1("k28_5_pre_rst", 10'b0011111010, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    drive_b1(1'b1, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk_b1("mid_rst", 10'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_b1("after_rst", 10'b1001110100, 1'b0, 1'b0, 1'b1);
    drive_b1(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // ---------------- bytes=2 ----------------
    drive_b2(1'b1, 1'b1, 1'b0, 2'b00, 16'h0000); tick();
    chk_b2("d0_0x2", {10'b1001110100, 10'b1001110100}, 1'b0, 2'b00, 1'b1);
    drive_b2(1'b1, 1'b1, 1'b0, 2'b10, 16'hBCB5); tick();
    chk_b2("k28_5_d21_5_rdm", {10'b0011111010, 10'b1010101010}, 1'b1, 2'b00, 1'b1);
    tick();
    chk_b2("k28_5_d21_5_rdp", {10'b1100000101, 10'b1010101010}, 1'b0, 2'b00, 1'b1);
    drive_b2(1'b1, 1'b1, 1'b0, 2'b01, 16'hB500); tick();
    chk_b2("k_err_byte0", {10'b1010101010, 10'b1001110100}, 1'b0, 2'b01, 1'b1);
    drive_b2(1'b1, 1'b0, 1'b1, 2'b00, 16'h0000); tick();
    chk_b2("init_imm", {10'b0110001011, 10'b0110001011}, 1'b1, 2'b00, 1'b1);
    drive_b2(1'b0, 1'b1, 1'b0, 2'b00, 16'h0000);

    // ---------------- k28_5_only ----------------
    drive_k5(1'b1, 1'b1, 1'b0, 1'b1, 8'h00); tick();
    chk_k5("k0_0_as_k28_5", 10'b0011111010, 1'b1, 1'b0, 1'b1);
    drive_k5(1'b1, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk_k5("d0_0_rdp", 10'b0110001011, 1'b1, 1'b0, 1'b1);
    drive_k5(1'b1, 1'b1, 1'b0, 1'b1, 8'h00); tick();
    chk_k5("k_as_k28_5_rdp", 10'b1100000101, 1'b0, 1'b0, 1'b1);
    drive_k5(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // ---------------- init_mode=0 ----------------
    drive_im0(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); tick();
    chk_im0("init_defer", 10'b1001110100, 1'b1, 1'b0, 1'b1);
    drive_im0(1'b1, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk_im0("after_init", 10'b0110001011, 1'b1, 1'b0, 1'b1);
    drive_im0(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF); tick();
    chk_im0("init_while_idle", 10'b0110001011, 1'b0, 1'b0, 1'b0);
    drive_im0(1'b1, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk_im0("from_loaded_rdm", 10'b1001110100, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
